rv_dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline MEM stage (CPU requester) and an external requester (debug/DMA, valid/ready).
- Sits between the MEM stage's dmem interface and the data memory.
- Memory is combinational-read: read data is valid in the same cycle as the address.
- CPU has priority. A wait counter guarantees the external requester a slot. An optional lock lets the external requester hold the port for a bounded burst.

---
 rtl/rv_dmem_arbiter_pkg.sv | 15 +
 rtl/rv_arb_sat_counter.sv | 23 ++
 rtl/rv_dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_rv_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package rv_dmem_arbiter_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned BYTECTRL_W        = 3;
    localparam int unsigned EXT_MAX_WAIT_DEF  = 8;
    localparam int unsigned EXT_MAX_BURST_DEF = 4;

    // ArbSExt: the external requester won the previous cycle with lock asserted.
    typedef enum logic {
        ArbSCpu = 1'b0,
        ArbSExt = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rv_arb_sat_counter.sv
// 8-bit up-counter with clear and a saturation limit; synchronous active-high reset.
module rv_arb_sat_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic [7:0] limit_i,
    output logic [7:0] count_o
);

    logic [7:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q < limit_i)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rv_dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and an external requester.
// Optional stall counter enabled by defining RV_DMEM_ARB_STALL_CNT_EN.
module rv_dmem_arbiter
    import rv_dmem_arbiter_pkg::*;
#(
    parameter int unsigned EXT_MAX_WAIT  = EXT_MAX_WAIT_DEF,
    parameter int unsigned EXT_MAX_BURST = EXT_MAX_BURST_DEF
) (
    input  logic                  i_arb_clk,
    input  logic                  i_arb_rst,
    input  logic                  i_arb_cpu_req,
    input  logic                  i_arb_cpu_we,
    input  logic [XLEN-1:0]       i_arb_cpu_a,
    input  logic [XLEN-1:0]       i_arb_cpu_wd,
    input  logic [BYTECTRL_W-1:0] i_arb_cpu_bytectrl,
    output logic [XLEN-1:0]       o_arb_cpu_rd,
    output logic                  o_arb_cpu_stall,
    input  logic                  i_arb_ext_valid,
    input  logic                  i_arb_ext_lock,
    input  logic                  i_arb_ext_we,
    input  logic [XLEN-1:0]       i_arb_ext_a,
    input  logic [XLEN-1:0]       i_arb_ext_wd,
    input  logic [BYTECTRL_W-1:0] i_arb_ext_bytectrl,
    output logic                  o_arb_ext_ready,
    output logic                  o_arb_ext_rvalid,
    output logic [XLEN-1:0]       o_arb_ext_rdata,
    input  logic [XLEN-1:0]       i_arb_dmem_rd,
    output logic [XLEN-1:0]       o_arb_dmem_a,
    output logic                  o_arb_dmem_we,
    output logic [XLEN-1:0]       o_arb_dmem_wd,
    output logic [BYTECTRL_W-1:0] o_arb_dmem_bytectrl,
    output logic [31:0]           o_arb_stall_cnt
);

    localparam logic [7:0] MaxWait  = 8'(EXT_MAX_WAIT);
    localparam logic [7:0] MaxBurst = 8'(EXT_MAX_BURST);

    arb_state_e state_q, state_d;
    logic [7:0] wait_cnt, burst_cnt;
    logic       force_grant, hold, ext_grant, burst_room;
    logic       rvalid_q;
    logic [XLEN-1:0] rdata_q;

    assign force_grant = (wait_cnt == MaxWait);
    assign hold        = (state_q == ArbSExt) && (burst_cnt < MaxBurst);
    // Gated by reset so no access is issued or accepted while reset is held.
    assign ext_grant   = !i_arb_rst && i_arb_ext_valid &&
                         (!i_arb_cpu_req || force_grant || hold);
    assign burst_room  = ({1'b0, burst_cnt} + 9'd1) < {1'b0, MaxBurst};

    rv_arb_sat_counter u_wait_cnt (
        .clk_i   (i_arb_clk),
        .rst_i   (i_arb_rst),
        .inc_i   (i_arb_ext_valid && !ext_grant),
        .clr_i   (ext_grant || !i_arb_ext_valid),
        .limit_i (MaxWait),
        .count_o (wait_cnt)
    );

    rv_arb_sat_counter u_burst_cnt (
        .clk_i   (i_arb_clk),
        .rst_i   (i_arb_rst),
        .inc_i   (ext_grant && i_arb_cpu_req && (state_q == ArbSExt)),
        .clr_i   (state_q == ArbSCpu),
        .limit_i (MaxBurst),
        .count_o (burst_cnt)
    );

    always_comb begin
        state_d = ArbSCpu;
        unique case (state_q)
            ArbSCpu: if (ext_grant && i_arb_ext_lock) state_d = ArbSExt;
            ArbSExt: begin
                if (ext_grant && i_arb_ext_lock && (!i_arb_cpu_req || burst_room)) begin
                    state_d = ArbSExt;
                end
            end
            default: state_d = ArbSCpu;
        endcase
    end

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            state_q  <= ArbSCpu;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= ext_grant && !i_arb_ext_we;
            if (ext_grant && !i_arb_ext_we) rdata_q <= i_arb_dmem_rd;
        end
    end

    always_comb begin
        o_arb_ext_ready     = ext_grant;
        o_arb_cpu_stall     = ext_grant && i_arb_cpu_req;
        o_arb_dmem_a        = i_arb_cpu_a;
        o_arb_dmem_wd       = i_arb_cpu_wd;
        o_arb_dmem_bytectrl = i_arb_cpu_bytectrl;
        o_arb_dmem_we       = i_arb_cpu_we && i_arb_cpu_req && !i_arb_rst;
        if (ext_grant) begin
            o_arb_dmem_a        = i_arb_ext_a;
            o_arb_dmem_wd       = i_arb_ext_wd;
            o_arb_dmem_bytectrl = i_arb_ext_bytectrl;
            o_arb_dmem_we       = i_arb_ext_we;
        end
    end

    assign o_arb_cpu_rd     = i_arb_dmem_rd;
    assign o_arb_ext_rvalid = rvalid_q;
    assign o_arb_ext_rdata  = rdata_q;

`ifdef RV_DMEM_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            stall_cnt_q <= '0;
        end else if (o_arb_cpu_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_arb_stall_cnt = stall_cnt_q;
`else
    assign o_arb_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Directed bench for rv_dmem_arbiter with a cycle-level reference model checked every cycle.
module tb_rv_dmem_arbiter;

    localparam int MAXW = 8;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_a, cpu_wd;
    logic [2:0]  cpu_bc;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        ext_valid, ext_lock, ext_we;
    logic [31:0] ext_a, ext_wd;
    logic [2:0]  ext_bc;
    logic        ext_ready, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] dmem_rd, dmem_a, dmem_wd;
    logic        dmem_we;
    logic [2:0]  dmem_bc;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    rv_dmem_arbiter #(.EXT_MAX_WAIT(MAXW), .EXT_MAX_BURST(MAXB)) dut (
        .i_arb_clk           (clk),
        .i_arb_rst           (rst),
        .i_arb_cpu_req       (cpu_req),
        .i_arb_cpu_we        (cpu_we),
        .i_arb_cpu_a         (cpu_a),
        .i_arb_cpu_wd        (cpu_wd),
        .i_arb_cpu_bytectrl  (cpu_bc),
        .o_arb_cpu_rd        (cpu_rd),
        .o_arb_cpu_stall     (cpu_stall),
        .i_arb_ext_valid     (ext_valid),
        .i_arb_ext_lock      (ext_lock),
        .i_arb_ext_we        (ext_we),
        .i_arb_ext_a         (ext_a),
        .i_arb_ext_wd        (ext_wd),
        .i_arb_ext_bytectrl  (ext_bc),
        .o_arb_ext_ready     (ext_ready),
        .o_arb_ext_rvalid    (ext_rvalid),
        .o_arb_ext_rdata     (ext_rdata),
        .i_arb_dmem_rd       (dmem_rd),
        .o_arb_dmem_a        (dmem_a),
        .o_arb_dmem_we       (dmem_we),
        .o_arb_dmem_wd       (dmem_wd),
        .o_arb_dmem_bytectrl (dmem_bc),
        .o_arb_stall_cnt     (stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: how long ext has waited, how many locked beats it has taken,
    // whether it holds the lock, and the pending read response.
    int          m_wait  = 0;
    int          m_burst = 0;
    bit          m_lock  = 1'b0;
    bit          m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_stall = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit g, cpu_wins_bus, stall_e, may_take;
            logic [31:0] sc_exp;
            may_take = !cpu_req || (m_wait == MAXW) || (m_lock && m_burst < MAXB);
            g = !rst && ext_valid && may_take;
            cpu_wins_bus = !g;
            stall_e = g && cpu_req;
`ifdef RV_DMEM_ARB_STALL_CNT_EN
            sc_exp = m_stall;
`else
            sc_exp = '0;
`endif
            check("m_ready",  {31'd0, ext_ready}, {31'd0, g});
            check("m_stall",  {31'd0, cpu_stall}, {31'd0, stall_e});
            check("m_dmem_a", dmem_a, cpu_wins_bus ? cpu_a : ext_a);
            check("m_dmem_wd", dmem_wd, cpu_wins_bus ? cpu_wd : ext_wd);
            check("m_dmem_bc", {29'd0, dmem_bc}, {29'd0, cpu_wins_bus ? cpu_bc : ext_bc});
            check("m_dmem_we", {31'd0, dmem_we},
                  {31'd0, cpu_wins_bus ? (cpu_we && cpu_req && !rst) : ext_we});
            check("m_cpu_rd", cpu_rd, dmem_rd);
            check("m_rvalid", {31'd0, ext_rvalid}, {31'd0, m_rvalid});
            check("m_rdata",  ext_rdata, m_rdata);
            check("m_stall_cnt", stall_cnt, sc_exp);

            if (rst) begin
                m_wait = 0; m_burst = 0; m_lock = 1'b0;
                m_rvalid = 1'b0; m_rdata = '0; m_stall = '0;
            end else begin
                if (!m_lock)         m_burst = 0;
                else if (g && cpu_req) m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
                m_lock = g && ext_lock && (!m_lock || !cpu_req || (m_burst < MAXB));
                // m_burst already advanced above, so the stay test reads the new count.
                if (g || !ext_valid) m_wait = 0;
                else if (m_wait < MAXW) m_wait = m_wait + 1;
                m_rvalid = g && !ext_we;
                if (g && !ext_we) m_rdata = dmem_rd;
                if (stall_e) m_stall = m_stall + 32'd1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grants;
        logic [31:0] sc6;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_a = '0; cpu_wd = '0; cpu_bc = 3'b000;
        ext_valid = 0; ext_lock = 0; ext_we = 0; ext_a = '0; ext_wd = '0; ext_bc = 3'b000;
        dmem_rd = '0;

        // Reset held with both sides requesting writes: nothing may reach memory.
        cyc();
        chk_en = 1'b1;
        cpu_req = 1; cpu_we = 1; ext_valid = 1; ext_we = 1;
        #2;
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_ready", {31'd0, ext_ready}, 32'd0);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);

        // CPU store only
        for (int k = 0; k < 3; k++) begin
            cyc();
            rst = 0; ext_valid = 0; ext_we = 0;
            cpu_req = 1; cpu_we = 1; cpu_a = 32'h100; cpu_wd = 32'hDEADBEEF; cpu_bc = 3'b010;
            #2;
            check("s1_we", {31'd0, dmem_we}, 32'd1);
            check("s1_a", dmem_a, 32'h100);
            check("s1_wd", dmem_wd, 32'hDEADBEEF);
            check("s1_stall", {31'd0, cpu_stall}, 32'd0);
        end

        // Contention: CPU owns the port for 8 cycles, then ext is force-granted
        for (int k = 0; k < 10; k++) begin
            cyc();
            cpu_req = 1; cpu_we = 0; cpu_a = 32'h200; cpu_bc = 3'b000;
            ext_valid = 1; ext_lock = 0; ext_we = 1; ext_a = 32'h300; ext_wd = 32'h0BADF00D;
            ext_bc = 3'b001; dmem_rd = 32'hA5A50000 + k;
            #2;
            if (k < 8) begin
                check("s2_wait_ready", {31'd0, ext_ready}, 32'd0);
                check("s2_wait_stall", {31'd0, cpu_stall}, 32'd0);
            end else if (k == 8) begin
                check("s2_force_ready", {31'd0, ext_ready}, 32'd1);
                check("s2_force_stall", {31'd0, cpu_stall}, 32'd1);
                check("s2_force_a", dmem_a, 32'h300);
            end else begin
                check("s2_after_ready", {31'd0, ext_ready}, 32'd0);
            end
        end

        // External read with the CPU idle
        cyc();
        cpu_req = 0; ext_valid = 1; ext_lock = 0; ext_we = 0; ext_a = 32'h40;
        dmem_rd = 32'h12345678;
        #2;
        check("s3_ready", {31'd0, ext_ready}, 32'd1);
        check("s3_a", dmem_a, 32'h40);
        cyc();
        ext_valid = 0; dmem_rd = 32'hCAFEF00D;
        #2;
        check("s3_rvalid", {31'd0, ext_rvalid}, 32'd1);
        check("s3_rdata", ext_rdata, 32'h12345678);
        cyc();
        #2;
        check("s3_rvalid_drop", {31'd0, ext_rvalid}, 32'd0);
        check("s3_rdata_hold", ext_rdata, 32'h12345678);

        // Locked burst: force grant plus four held beats, then the CPU gets a cycle
        grants = 0;
`ifdef RV_DMEM_ARB_STALL_CNT_EN
        sc6 = 32'd6;
`else
        sc6 = 32'd0;
`endif
        for (int k = 0; k < 14; k++) begin
            cyc();
            cpu_req = 1; cpu_we = 0; cpu_a = 32'h500;
            ext_valid = 1; ext_lock = 1; ext_we = 0; ext_a = 32'h80;
            dmem_rd = 32'h00001000 + k;
            #2;
            grants += int'(ext_ready);
            if (k == 13) begin
                check("s4_cpu_back_ready", {31'd0, ext_ready}, 32'd0);
                check("s4_cpu_back_stall", {31'd0, cpu_stall}, 32'd0);
                check("s6_stall_cnt", stall_cnt, sc6);
            end
        end
        check("s4_grants", grants, 32'd5);

        // Reset while locked with a read response pending
        cyc();
        cpu_req = 0; ext_valid = 1; ext_lock = 1; ext_we = 0; ext_a = 32'h44;
        dmem_rd = 32'h55AA55AA;
        #2;
        check("s5_lock_grant", {31'd0, ext_ready}, 32'd1);
        cyc();
        rst = 1; cpu_req = 1; cpu_we = 1; ext_we = 1;
        #2;
        check("s5_rst_ready", {31'd0, ext_ready}, 32'd0);
        check("s5_rst_we", {31'd0, dmem_we}, 32'd0);
        check("s5_rst_stall", {31'd0, cpu_stall}, 32'd0);
        cyc();
        rst = 0; cpu_we = 0; ext_lock = 0; ext_we = 0;
        #2;
        check("s5_rvalid", {31'd0, ext_rvalid}, 32'd0);
        check("s5_rdata", ext_rdata, 32'd0);
        check("s5_stall_cnt", stall_cnt, 32'd0);
        check("s5_cpu_state", {31'd0, ext_ready}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            cyc();
            ext_valid = 0; cpu_req = k[0]; cpu_we = 1; cpu_a = 32'h600 + k;
        end
        cyc();
        #5;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
